// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  // Controller states: waiting for operands, shifting bits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width for a given operand width. It only has to reach WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: x - y - bin = d - 2*bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of one bit position.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. start_ready is high only in IDLE, done_valid only in DONE; both
// are decoded from the state register, so neither depends combinationally on
// start_valid or done_ready. Once done_valid is high, diff/bout/ovf stay
// constant until the consumer takes the result.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output state_t           state_dbg
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;

  logic             d_bit;
  logic             borrow_next;

  // The one bit slice, fed by the LSBs of the shift registers.
  full_subtractor u_bit (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_next)
  );

  // Controller, operand shifters, result shifter and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            diff_r <= '0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            state  <= RUN;
          end
        end
        RUN: begin
          diff_r <= {d_bit, diff_r[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // d_bit here is the result MSB; overflow needs opposite operand
            // signs and a result sign differing from the minuend.
            bout_r <= borrow_next;
            ovf_r  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decoded from state only.
  always_comb begin
    start_ready = (state == IDLE);
    done_valid  = (state == DONE);
    diff        = diff_r;
    bout        = bout_r;
    ovf         = ovf_r;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8) and its full_subtractor cell.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT ----------------
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         done_valid;
  logic         done_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  state_t       state_dbg;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .diff        (diff),
    .bout        (bout),
    .ovf         (ovf),
    .state_dbg   (state_dbg)
  );

  logic fs_x = 1'b0, fs_y = 1'b0, fs_bin = 1'b0;
  logic fs_d, fs_bout;

  full_subtractor u_fs (
    .x    (fs_x),
    .y    (fs_y),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];   // {ovf, bout, diff}
  int accept_cyc = 0;
  int last_rise  = -1;
  bit soak_mode  = 1'b0;
  bit prev_dv    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic ibin);
    int ua, ub, sa, sb, r, s;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    r  = ua - ub - int'(ibin);
    s  = sa - sb - int'(ibin);
    d  = W'(r);
    bo = (ua < ub + int'(ibin));
    ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return {ov, bo, d};
  endfunction

  // Per-cycle compare whenever the result is qualified.
  always @(negedge clk) begin
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (done_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(done_valid), 32'd0);
        end else begin
          check("result_vs_model", 32'({ovf, bout, diff}), 32'(exp_q[0]));
        end
        if (!prev_dv) begin
          check("latency", 32'(cyc - accept_cyc), 32'(W));
          if (soak_mode && last_rise >= 0) check("spacing", 32'(cyc - last_rise), 32'(W + 2));
          last_rise = cyc;
        end
        check("start_ready_in_done", 32'(start_ready), 32'd0);
        if (done_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_dv = done_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready) begin
      check("send_timeout", 32'(start_ready), 32'd1);
    end else begin
      a = ia; b = ib; bin = ibin; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      exp_q.push_back(model(ia, ib, ibin));
      accept_cyc = cyc;
    end
  endtask

  // Returns at the falling edge where done_valid is seen.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done_valid) check({name, "_timeout"}, 32'(done_valid), 32'd1);
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] ed, input logic eb,
                            input logic eo);
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_bout"}, 32'(bout), 32'(eb));
    check({name, "_ovf"},  32'(ovf),  32'(eo));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    // Async reset with no clock edge yet.
    #3;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_outs", 32'({ovf, bout, diff}), 32'd0);

    // Cell: exhaustive against x - y - bin = d - 2*bout.
    for (int i = 0; i < 8; i++) begin
      int r;
      logic [2:0] v;
      v = 3'(i);
      fs_x = v[2]; fs_y = v[1]; fs_bin = v[0];
      #1;
      r = int'(v[2]) - int'(v[1]) - int'(v[0]);
      check("fs_d", 32'(fs_d), 32'(r & 1));
      check("fs_bout", 32'(fs_bout), 32'(r < 0));
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Model pinned against hand-computed vectors, then DUT against both.
    foreach (vecs[i]) begin
      logic [W+1:0] m;
      m = model(vecs[i].va, vecs[i].vb, vecs[i].vbin);
      check("model_pin", 32'(m), 32'({vecs[i].eo, vecs[i].eb, vecs[i].ed}));
      send(vecs[i].va, vecs[i].vb, vecs[i].vbin);
      wait_done("vec");
      expect_lit("vec", vecs[i].ed, vecs[i].eb, vecs[i].eo);
      @(posedge clk); #1;
      check("vec_back_idle", 32'(start_ready), 32'd1);
    end

    // Outputs hold their last result through IDLE.
    repeat (3) @(posedge clk);
    #1;
    expect_lit("idle_hold", 8'h80, 1'b1, 1'b1);

    // Backpressure: 0x3C - 0x5A - 1 = -31 -> 0xE1, borrow, no overflow.
    done_ready = 1'b0;
    send(8'h3C, 8'h5A, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'h00; bin = 1'b0; start_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_done("bp");
    expect_lit("bp", 8'hE1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start_valid = (k == 2);
      check("bp_hold_valid", 32'(done_valid), 32'd1);
      check("bp_hold_ready", 32'(start_ready), 32'd0);
      expect_lit("bp_hold", 8'hE1, 1'b1, 1'b0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(done_valid), 32'd0);
    check("bp_release_ready", 32'(start_ready), 32'd1);

    // Reset three cycles into a run.
    send(8'h33, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_ready", 32'(start_ready), 32'd1);
    check("midrst_valid", 32'(done_valid), 32'd0);
    check("midrst_outs", 32'({ovf, bout, diff}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h0A, 8'h0A, 1'b0);
    wait_done("after_rst");
    expect_lit("after_rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Back-to-back soak with done_ready held high.
    soak_mode = 1'b1;
    last_rise = -1;
    for (int k = 0; k < 200; k++) begin
      send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("soak_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
